lfsr_sweep_ctrl: RTL and testbench

LFSR_SWEEP_CTRL -- requirements
Module: lfsr_sweep_ctrl

---
 rtl/lfsr_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lfsr_sweep_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sweep_ctrl.sv
// Sweep controller for a multi-width LFSR: steps lfsr_mode from mode_first to mode_last, run_len cycles per mode.
// Define LFSR_SWEEP_CAPTURE_EN to build the snap_valid/snap_mode/snap_data end-of-mode capture outputs.
module lfsr_sweep_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic             hold,
  input  logic [CNT_W-1:0] run_len,
  input  logic [1:0]       mode_first,
  input  logic [1:0]       mode_last,
  input  logic [10:0]      lfsr_out_i,
  output logic             lfsr_start,
  output logic             lfsr_stop,
  output logic [1:0]       lfsr_mode,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cur_cnt
`ifdef LFSR_SWEEP_CAPTURE_EN
  ,
  output logic             snap_valid,
  output logic [1:0]       snap_mode,
  output logic [10:0]      snap_data
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             start_r, start_s;
  logic             stop_r, stop_s;
  logic [1:0]       mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] run_len_r, run_len_s;
  logic [1:0]       last_r, last_s;
  logic [CNT_W-1:0] reload_s;
  logic             tc_s;
  logic             abortable_s;

  // run_len of zero wraps to all-ones, giving 2^CNT_W cycles per mode
  assign reload_s    = run_len_r - CNT_ONE;
  assign abortable_s = (state_r == ST_START) || (state_r == ST_RUN) || (state_r == ST_PAUSE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: abort beats hold, hold beats terminal count
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (go) state_s = ST_START; else state_s = ST_IDLE;
      ST_START: if (abort) state_s = ST_IDLE; else state_s = ST_RUN;
      ST_RUN: begin
        if (abort)                                       state_s = ST_IDLE;
        else if (hold)                                   state_s = ST_PAUSE;
        else if ((cnt_r == CNT_ZERO) && (mode_r == last_r)) state_s = ST_DONE;
        else                                             state_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (abort)     state_s = ST_IDLE;
        else if (hold) state_s = ST_PAUSE;
        else           state_s = ST_RUN;
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values, registered below
  always_comb begin
    start_s   = (state_s == ST_START);
    done_s    = (state_s == ST_DONE);
    busy_s    = (state_s != ST_IDLE);
    stop_s    = (state_s == ST_PAUSE) || (abort && abortable_s);
    mode_s    = mode_r;
    cnt_s     = cnt_r;
    run_len_s = run_len_r;
    last_s    = last_r;
    tc_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          run_len_s = run_len;
          last_s    = mode_last;
          mode_s    = mode_first;
        end else begin
          run_len_s = run_len_r;
        end
      end
      ST_START: begin
        if (abort) cnt_s = cnt_r; else cnt_s = reload_s;
      end
      ST_RUN: begin
        if (abort || hold) begin
          cnt_s = cnt_r;
        end else if (cnt_r == CNT_ZERO) begin
          tc_s = 1'b1;
          // mode advance keeps the LFSR running; no new start pulse
          if (mode_r != last_r) begin
            mode_s = mode_r + 2'd1;
            cnt_s  = reload_s;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: cnt_s = cnt_r;
    endcase
  end

  // Output and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r   <= 1'b0;
      stop_r    <= 1'b0;
      mode_r    <= 2'b00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cnt_r     <= CNT_ZERO;
      run_len_r <= CNT_ZERO;
      last_r    <= 2'b00;
    end else begin
      start_r   <= start_s;
      stop_r    <= stop_s;
      mode_r    <= mode_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      cnt_r     <= cnt_s;
      run_len_r <= run_len_s;
      last_r    <= last_s;
    end
  end

  assign lfsr_start = start_r;
  assign lfsr_stop  = stop_r;
  assign lfsr_mode  = mode_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cur_cnt    = cnt_r;

`ifdef LFSR_SWEEP_CAPTURE_EN
  logic        snap_valid_r;
  logic [1:0]  snap_mode_r;
  logic [10:0] snap_data_r;

  // Capture the LFSR value at each consumed terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid_r <= 1'b0;
      snap_mode_r  <= 2'b00;
      snap_data_r  <= 11'd0;
    end else begin
      snap_valid_r <= tc_s;
      if (tc_s) begin
        snap_mode_r <= mode_r;
        snap_data_r <= lfsr_out_i;
      end else begin
        snap_mode_r <= snap_mode_r;
        snap_data_r <= snap_data_r;
      end
    end
  end

  assign snap_valid = snap_valid_r;
  assign snap_mode  = snap_mode_r;
  assign snap_data  = snap_data_r;
`else
  logic unused_s;
  assign unused_s = ^{lfsr_out_i, tc_s};
`endif

endmodule

// File: tb/tb_lfsr_sweep_ctrl.sv
// Directed self-checking bench for lfsr_sweep_ctrl; snapshot checks are built when LFSR_SWEEP_CAPTURE_EN is defined.
module tb_lfsr_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  run_len = 8'd0;
  logic [1:0]  mode_first = 2'd0;
  logic [1:0]  mode_last = 2'd0;
  logic [10:0] lfsr_out_i = 11'd0;
  logic        lfsr_start, lfsr_stop, busy, done;
  logic [1:0]  lfsr_mode;
  logic [7:0]  cur_cnt;
`ifdef LFSR_SWEEP_CAPTURE_EN
  logic        snap_valid;
  logic [1:0]  snap_mode;
  logic [10:0] snap_data;
`endif

  int checks = 0;
  int errors = 0;

  lfsr_sweep_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .hold(hold),
    .run_len(run_len), .mode_first(mode_first), .mode_last(mode_last),
    .lfsr_out_i(lfsr_out_i), .lfsr_start(lfsr_start), .lfsr_stop(lfsr_stop),
    .lfsr_mode(lfsr_mode), .busy(busy), .done(done), .cur_cnt(cur_cnt)
`ifdef LFSR_SWEEP_CAPTURE_EN
    , .snap_valid(snap_valid), .snap_mode(snap_mode), .snap_data(snap_data)
`endif
  );

  always #5 clk = ~clk;

  task test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lfsr_start, lfsr_stop, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, required 0000", {lfsr_start, lfsr_stop, busy, done});
    end
    checks++;
    if (lfsr_mode !== 2'd0 || cur_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mode_cnt: got mode=%0d cnt=%0d, required 0 0", lfsr_mode, cur_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b, required 0", busy);
    end
  endtask

  task test_full_sweep;
    int starts;
    logic [1:0] e_mode;
    logic [7:0] e_cnt;
    run_len = 8'd4; mode_first = 2'd0; mode_last = 2'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (lfsr_start !== 1'b1 || lfsr_mode !== 2'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL full_start: got start=%b mode=%0d busy=%b, required 1 0 1", lfsr_start, lfsr_mode, busy);
    end
    starts = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (lfsr_start) starts++;
      e_mode = 2'(i / 4);
      e_cnt  = 8'(3 - (i % 4));
      checks++;
      if (lfsr_mode !== e_mode || cur_cnt !== e_cnt || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL full_run[%0d]: got mode=%0d cnt=%0d done=%b busy=%b, required %0d %0d 0 1", i, lfsr_mode, cur_cnt, done, busy, e_mode, e_cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL full_done: got done=%b busy=%b at cycle 18, required 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || starts !== 0) begin
      errors++; $display("FAIL full_after: got done=%b busy=%b extra_starts=%0d, required 0 0 0", done, busy, starts);
    end
  endtask

  task test_wrap;
    int starts;
    logic [1:0] e_mode;
    run_len = 8'd2; mode_first = 2'd3; mode_last = 2'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = lfsr_start ? 1 : 0;
    checks++;
    if (lfsr_mode !== 2'd3) begin
      errors++; $display("FAIL wrap_first: got mode=%0d, required 3", lfsr_mode);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (lfsr_start) starts++;
      e_mode = 2'(3 + i / 2);
      checks++;
      if (lfsr_mode !== e_mode || cur_cnt !== 8'(1 - (i % 2))) begin
        errors++; $display("FAIL wrap_run[%0d]: got mode=%0d cnt=%0d, required %0d %0d", i, lfsr_mode, cur_cnt, e_mode, 1 - (i % 2));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || starts !== 1) begin
      errors++; $display("FAIL wrap_done: got done=%b starts=%0d, required 1 1", done, starts);
    end
    @(negedge clk);
  endtask

  task test_hold;
    logic [7:0] e_cnt [9];
    logic       e_stop [9];
    e_cnt  = '{8'd4, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
    e_stop = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_len = 8'd5; mode_first = 2'd0; mode_last = 2'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (cur_cnt !== e_cnt[i] || lfsr_stop !== e_stop[i] || done !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got cnt=%0d stop=%b done=%b, required %0d %b 0", i, cur_cnt, lfsr_stop, done, e_cnt[i], e_stop[i]);
      end
      if (i == 2) hold = 1'b1;
      else if (i == 5) hold = 1'b0;
      else hold = hold;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL hold_done: got done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task test_hold_tc;
    run_len = 8'd2; mode_first = 2'd1; mode_last = 2'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cur_cnt !== 8'd0) begin
      errors++; $display("FAIL holdtc_pre: got cnt=%0d, required 0", cur_cnt);
    end
    hold = 1'b1;
    @(negedge clk);
    checks++;
    if (lfsr_stop !== 1'b1 || cur_cnt !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL holdtc_pause: got stop=%b cnt=%0d done=%b, required 1 0 0", lfsr_stop, cur_cnt, done);
    end
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if (lfsr_stop !== 1'b0 || cur_cnt !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL holdtc_resume: got stop=%b cnt=%0d done=%b, required 0 0 0", lfsr_stop, cur_cnt, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL holdtc_done: got done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task test_abort_back_to_back;
    run_len = 8'd4; mode_first = 2'd0; mode_last = 2'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    checks++;
    if (lfsr_start !== 1'b0 || lfsr_mode !== 2'd0 || cur_cnt !== 8'd2) begin
      errors++; $display("FAIL busy_go: got start=%b mode=%0d cnt=%0d, required 0 0 2", lfsr_start, lfsr_mode, cur_cnt);
    end
    go = 1'b0;
    @(negedge clk);
    abort = 1'b1; hold = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lfsr_stop !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b stop=%b done=%b, required 0 1 0", busy, lfsr_stop, done);
    end
    abort = 1'b0; hold = 1'b0;
    run_len = 8'd1; mode_first = 2'd2; mode_last = 2'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (lfsr_start !== 1'b1 || lfsr_mode !== 2'd2 || lfsr_stop !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_start: got start=%b mode=%0d stop=%b busy=%b, required 1 2 0 1", lfsr_start, lfsr_mode, lfsr_stop, busy);
    end
    @(negedge clk);
    checks++;
    if (cur_cnt !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_run: got cnt=%0d done=%b, required 0 0", cur_cnt, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task test_runlen_zero;
    int bad;
    run_len = 8'd0; mode_first = 2'd2; mode_last = 2'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (lfsr_mode !== 2'd2 || cur_cnt !== 8'(255 - i) || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rl0_run: got %0d bad RUN cycles, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL rl0_done: got done=%b after 256 cycles, required 1", done);
    end
    @(negedge clk);
  endtask

  task test_async_reset;
    logic [10:0] last_drv;
`ifdef LFSR_SWEEP_CAPTURE_EN
    int nsnap;
    logic [1:0] e_snap;
`endif
    run_len = 8'd3; mode_first = 2'd1; mode_last = 2'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lfsr_start, lfsr_stop, busy, done, lfsr_mode, cur_cnt} !== 14'd0) begin
      errors++; $display("FAIL async_reset: got outputs=%h, required 0", {lfsr_start, lfsr_stop, busy, done, lfsr_mode, cur_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_wait: got busy=%b done=%b, required 0 0", busy, done);
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (lfsr_start !== 1'b1 || lfsr_mode !== 2'd1) begin
      errors++; $display("FAIL restart: got start=%b mode=%0d, required 1 1", lfsr_start, lfsr_mode);
    end
`ifdef LFSR_SWEEP_CAPTURE_EN
    nsnap = 0;
    e_snap = 2'd1;
`endif
    for (int k = 0; k < 10; k++) begin
      lfsr_out_i = 11'h100 + 11'(k);
      last_drv = lfsr_out_i;
      @(negedge clk);
      checks++;
      if (k < 9) begin
        if (lfsr_mode !== 2'(1 + k / 3) || cur_cnt !== 8'(2 - (k % 3))) begin
          errors++; $display("FAIL restart_run[%0d]: got mode=%0d cnt=%0d, required %0d %0d", k, lfsr_mode, cur_cnt, 1 + k / 3, 2 - (k % 3));
        end
      end else begin
        if (done !== 1'b1) begin
          errors++; $display("FAIL restart_done: got done=%b, required 1", done);
        end
      end
`ifdef LFSR_SWEEP_CAPTURE_EN
      if (snap_valid === 1'b1) begin
        nsnap++;
        checks++;
        if (snap_mode !== e_snap || snap_data !== last_drv) begin
          errors++; $display("FAIL snap[%0d]: got mode=%0d data=%h, required %0d %h", k, snap_mode, snap_data, e_snap, last_drv);
        end
        e_snap = e_snap + 2'd1;
      end
`endif
    end
`ifdef LFSR_SWEEP_CAPTURE_EN
    checks++;
    if (nsnap !== 3) begin
      errors++; $display("FAIL snap_count: got %0d, required 3", nsnap);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_wrap();
    test_hold();
    test_hold_tc();
    test_abort_back_to_back();
    test_runlen_zero();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
